// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues loads/stores to big-endian byte memory, merges sub-word
// stores by read-modify-write, and registers one result per operation for write-back.
module mem_access_ctrl #(
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [29:0] in_addr,
   input  logic [31:0] in_data,
   input  logic [4:0]  in_rd,
   output logic [29:0] memory_addr,
   output logic        memory_as_,
   output logic        memory_rw,
   output logic [31:0] memory_wr_data,
   input  logic [31:0] memory_rd_data,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign_exc,
   output logic [29:0] exc_addr
);
   typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

   state_t      state_reg, state_next;
   logic [29:0] lat_addr_reg;
   logic        lat_half_reg;
   logic [15:0] lat_data_reg;
   logic [31:0] lat_old_reg;
   logic [4:0]  lat_rd_reg;

   logic        accept, op_load, op_store, sz_byte, sz_half, sz_word, misaligned;
   logic        do_load, do_wstore, do_rmw;
   logic [31:0] load_val, new_word, merged_word;
   logic [3:0]  lane_mask;

   assign in_ready   = (state_reg == IDLE);
   assign accept     = in_valid & in_ready;
   assign op_load    = (in_op == 2'b01);
   assign op_store   = (in_op == 2'b10);
   assign sz_byte    = (in_size == 2'b00);
   assign sz_half    = (in_size == 2'b01);
   assign sz_word    = in_size[1];
   assign misaligned = MISALIGN_EN & (op_load | op_store) &
                       ((sz_half & in_addr[0]) | (sz_word & (in_addr[1:0] != 2'b00)));
   assign do_load    = accept & op_load & ~misaligned;
   assign do_wstore  = accept & op_store & sz_word & ~misaligned;
   assign do_rmw     = accept & op_store & ~sz_word & ~misaligned;

   // The addressed byte is always the most significant lane of the read word.
   always_comb begin
      load_val = memory_rd_data;
      if (sz_byte)
         load_val = {{24{~in_unsigned & memory_rd_data[31]}}, memory_rd_data[31:24]};
      else if (sz_half)
         load_val = {{16{~in_unsigned & memory_rd_data[31]}}, memory_rd_data[31:16]};
   end

   assign new_word  = lat_half_reg ? {lat_data_reg, 16'h0000} : {lat_data_reg[7:0], 24'h000000};
   assign lane_mask = lat_half_reg ? 4'b1100 : 4'b1000;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign merged_word[8*gi +: 8] = lane_mask[gi] ? new_word[8*gi +: 8] : lat_old_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (do_rmw) state_next = RMW_WR;
         RMW_WR:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      memory_as_     = 1'b1;
      memory_rw      = 1'b1;
      memory_addr    = '0;
      memory_wr_data = '0;
      case (state_reg)
         RMW_WR: begin
            memory_as_     = 1'b0;
            memory_rw      = 1'b0;
            memory_addr    = lat_addr_reg;
            memory_wr_data = merged_word;
         end
         default: begin
            if (do_load | do_rmw) begin
               memory_as_  = 1'b0;
               memory_addr = in_addr;
            end else if (do_wstore) begin
               memory_as_     = 1'b0;
               memory_rw      = 1'b0;
               memory_addr    = in_addr;
               memory_wr_data = in_data;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         lat_addr_reg <= '0;
         lat_half_reg <= 1'b0;
         lat_data_reg <= '0;
         lat_old_reg  <= '0;
         lat_rd_reg   <= '0;
      end else if (do_rmw) begin
         lat_addr_reg <= in_addr;
         lat_half_reg <= sz_half;
         lat_data_reg <= in_data[15:0];
         lat_old_reg  <= memory_rd_data;
         lat_rd_reg   <= in_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         misalign_exc <= 1'b0;
         exc_addr     <= '0;
      end else begin
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         misalign_exc <= 1'b0;
         if (state_reg == RMW_WR) begin
            wb_valid <= 1'b1;
            wb_rd    <= lat_rd_reg;
         end else if (accept) begin
            if (misaligned) begin
               wb_valid     <= 1'b1;
               misalign_exc <= 1'b1;
               exc_addr     <= in_addr;
               wb_rd        <= in_rd;
            end else if (op_load) begin
               wb_valid <= 1'b1;
               wb_we    <= (in_rd != 5'd0);
               wb_rd    <= in_rd;
               wb_data  <= load_val;
            end else if (op_store) begin
               // Sub-word stores report from RMW_WR instead.
               if (sz_word) begin
                  wb_valid <= 1'b1;
                  wb_rd    <= in_rd;
               end
            end else begin
               wb_valid <= 1'b1;
               wb_we    <= (in_rd != 5'd0);
               wb_rd    <= in_rd;
               wb_data  <= in_data;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-array memory, queue-based result model,
// per-cycle write-back compare plus directed literal checks.
module tb_mem_access_ctrl;
   logic        clk = 1'b0;
   logic        rst_ = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = '0;
   logic [1:0]  in_size = '0;
   logic        in_unsigned = 1'b0;
   logic [29:0] in_addr = '0;
   logic [31:0] in_data = '0;
   logic [4:0]  in_rd = '0;
   logic [29:0] memory_addr;
   logic        memory_as_;
   logic        memory_rw;
   logic [31:0] memory_wr_data;
   logic [31:0] memory_rd_data;
   logic        wb_valid, wb_we, misalign_exc;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [29:0] exc_addr;

   always #5 clk = ~clk;

   mem_access_ctrl #(.MISALIGN_EN(1'b1)) dut (
      .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
      .in_data(in_data), .in_rd(in_rd), .memory_addr(memory_addr), .memory_as_(memory_as_),
      .memory_rw(memory_rw), .memory_wr_data(memory_wr_data), .memory_rd_data(memory_rd_data),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .misalign_exc(misalign_exc), .exc_addr(exc_addr)
   );

   // Memory: 256 bytes, addresses wrap.
   logic [7:0]  mem [0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   always_comb begin
      logic [7:0] a;
      a = memory_addr[7:0];
      memory_rd_data = {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
   end

   always @(posedge clk) begin
      if (pl_en) begin
         for (int k = 0; k < 4; k++) mem[8'(pl_addr + 8'(k))] <= pl_data[31-8*k -: 8];
      end else if (!memory_as_ && !memory_rw) begin
         for (int k = 0; k < 4; k++) mem[8'(memory_addr[7:0] + 8'(k))] <= memory_wr_data[31-8*k -: 8];
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference model
   typedef struct {
      int          cyc;
      logic        we;
      logic        exc;
      logic        chk_data;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [29:0] exc_addr;
      int          undo_n;
      logic [7:0]  undo_a;
      logic [31:0] undo_b;
   } exp_t;

   logic [7:0] ref_mem [0:255];
   exp_t       q[$];

   function automatic int rb(input logic [7:0] a, input int k);
      return int'(ref_mem[8'(a + 8'(k))]);
   endfunction

   task automatic model_accept(input logic [1:0] op, input logic [1:0] size, input logic uns,
                               input logic [29:0] addr, input logic [31:0] data, input logic [4:0] rd);
      exp_t e;
      int o, s, n, v;
      logic [7:0] a;
      logic mis;
      e = '{cyc: cyc + 1, we: 1'b0, exc: 1'b0, chk_data: 1'b0, rd: rd, data: '0,
            exc_addr: '0, undo_n: 0, undo_a: '0, undo_b: '0};
      o = (op == 2'd3) ? 0 : int'(op);
      s = (size == 2'd3) ? 2 : int'(size);
      a = addr[7:0];
      mis = (o != 0) && ((s == 1 && addr % 2 != 0) || (s == 2 && addr % 4 != 0));
      if (mis) begin
         e.exc = 1'b1;
         e.exc_addr = addr;
      end else if (o == 0) begin
         e.we = (rd != 0);
         e.data = data;
         e.chk_data = 1'b1;
      end else if (o == 1) begin
         e.we = (rd != 0);
         e.chk_data = 1'b1;
         if (s == 0) begin
            v = rb(a, 0);
            if (!uns && v >= 128) v = v - 256;
         end else if (s == 1) begin
            v = rb(a, 0) * 256 + rb(a, 1);
            if (!uns && v >= 32768) v = v - 65536;
         end else begin
            v = (rb(a, 0) << 24) | (rb(a, 1) << 16) | (rb(a, 2) << 8) | rb(a, 3);
         end
         e.data = 32'(v);
      end else begin
         n = (s == 0) ? 1 : (s == 1) ? 2 : 4;
         e.undo_n = n;
         e.undo_a = a;
         for (int k = 0; k < n; k++) begin
            e.undo_b[8*k +: 8] = ref_mem[8'(a + 8'(k))];
            ref_mem[8'(a + 8'(k))] = 8'(data >> (8 * (n - 1 - k)));
         end
         if (n < 4) e.cyc = cyc + 2;
      end
      q.push_back(e);
   endtask

   // Reset drops any pending operation, including its memory effect.
   task automatic model_reset();
      foreach (q[i]) begin
         if (q[i].cyc > cyc + 1 || q[i].undo_n < 4) begin
            for (int k = 0; k < q[i].undo_n; k++) ref_mem[8'(q[i].undo_a + 8'(k))] = q[i].undo_b[8*k +: 8];
         end
      end
      q.delete();
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (rst_) begin
         if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("wb_missed_cycle", 32'(cyc), 32'(q[0].cyc));
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_we", 32'(wb_we), 32'(q[0].we));
            chk("misalign_exc", 32'(misalign_exc), 32'(q[0].exc));
            if (q[0].we) chk("wb_rd", 32'(wb_rd), 32'(q[0].rd));
            if (q[0].chk_data) chk("wb_data", wb_data, q[0].data);
            if (q[0].exc) chk("exc_addr", 32'(exc_addr), 32'(q[0].exc_addr));
            $display("wb cyc=%0d rd=%0d data=%h we=%b exc=%b", cyc, wb_rd, wb_data, wb_we, misalign_exc);
            void'(q.pop_front());
         end else begin
            chk("wb_valid_idle", 32'(wb_valid), 32'd0);
            chk("wb_we_idle", 32'(wb_we), 32'd0);
            chk("misalign_exc_idle", 32'(misalign_exc), 32'd0);
         end
      end
   end

   // Bus monitor
   int n_rd = 0, n_wr = 0;
   int pulse_q[$];
   always @(negedge clk) begin
      if (rst_ && !memory_as_) begin
         if (memory_rw) n_rd++;
         else n_wr++;
         $display("bus cyc=%0d %s addr=%h wdata=%h", cyc, memory_rw ? "RD" : "WR", memory_addr, memory_wr_data);
      end
      if (rst_ && wb_valid) pulse_q.push_back(cyc);
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) ref_mem[8'(a + 8'(k))] = w[31-8*k -: 8];
      pl_en = 1'b1; pl_addr = a; pl_data = w;
      sync();
      pl_en = 1'b0;
   endtask

   // Call at #1 after a rising edge; returns #1 after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                        input logic [29:0] addr, input logic [31:0] data, input logic [4:0] rd);
      int waited;
      in_valid = 1'b1; in_op = op; in_size = size; in_unsigned = uns;
      in_addr = addr; in_data = data; in_rd = rd;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 32'(in_ready), 32'd1);
      end else begin
         model_accept(op, size, uns, addr, data, rd);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_as"}, 32'(memory_as_), 32'd1);
      chk({tag, "_rw"}, 32'(memory_rw), 32'd1);
      chk({tag, "_addr"}, 32'(memory_addr), 32'd0);
      chk({tag, "_wdata"}, memory_wr_data, 32'd0);
      chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
      chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
      chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
      chk({tag, "_wb_data"}, wb_data, 32'd0);
      chk({tag, "_exc"}, 32'(misalign_exc), 32'd0);
      chk({tag, "_exc_addr"}, 32'(exc_addr), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   localparam logic [1:0] OP_NONE = 2'd0, OP_LD = 2'd1, OP_ST = 2'd2;
   localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

   initial begin
      int r0, w0;
      #2 rst_ = 1'b0;
      sync();
      preload(8'h20, 32'h11223344);
      preload(8'h40, 32'h80017FFF);
      preload(8'h30, 32'h55667788);
      preload(8'h08, 32'hA1B2C3D4);
      @(negedge clk);
      chk_reset_state("reset");
      sync();
      rst_ = 1'b1;
      sync();

      // Word store then word load
      w0 = n_wr;
      issue(OP_ST, SZ_W, 1'b0, 30'h10, 32'hDEADBEEF, 5'd7);
      issue(OP_LD, SZ_W, 1'b0, 30'h10, 32'h0, 5'd5);
      @(negedge clk);
      chk("t1_load_data", wb_data, 32'hDEADBEEF);
      chk("t1_load_we", 32'(wb_we), 32'd1);
      chk("t1_write_count", 32'(n_wr - w0), 32'd1);
      sync();

      // Byte store by read-modify-write, then signed byte load
      r0 = n_rd; w0 = n_wr;
      issue(OP_ST, SZ_B, 1'b0, 30'h20, 32'h000000AB, 5'd0);
      chk("t2_in_ready_rmw", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("t2_rmw_as", 32'(memory_as_), 32'd0);
      chk("t2_rmw_rw", 32'(memory_rw), 32'd0);
      chk("t2_rmw_addr", 32'(memory_addr), 32'h20);
      chk("t2_rmw_wdata", memory_wr_data, 32'hAB223344);
      chk("t2_read_count", 32'(n_rd - r0), 32'd1);
      sync();
      chk("t2_write_count", 32'(n_wr - w0), 32'd1);
      issue(OP_LD, SZ_B, 1'b0, 30'h20, 32'h0, 5'd9);
      @(negedge clk);
      chk("t2_load_sbyte", wb_data, 32'hFFFFFFAB);
      sync();

      // Half loads, unsigned and signed
      issue(OP_LD, SZ_H, 1'b1, 30'h40, 32'h0, 5'd1);
      @(negedge clk);
      chk("t3_half_unsigned", wb_data, 32'h00008001);
      sync();
      issue(OP_LD, SZ_H, 1'b0, 30'h40, 32'h0, 5'd2);
      @(negedge clk);
      chk("t3_half_signed", wb_data, 32'hFFFF8001);
      sync();
      issue(OP_LD, SZ_B, 1'b1, 30'h43, 32'h0, 5'd12);
      issue(OP_LD, SZ_H, 1'b0, 30'h42, 32'h0, 5'd13);

      // Misaligned accesses: no bus cycle
      r0 = n_rd + n_wr;
      issue(OP_LD, SZ_W, 1'b0, 30'h13, 32'h0, 5'd4);
      @(negedge clk);
      chk("t4_exc", 32'(misalign_exc), 32'd1);
      chk("t4_exc_addr", 32'(exc_addr), 32'h13);
      chk("t4_we", 32'(wb_we), 32'd0);
      chk("t4_no_bus", 32'(n_rd + n_wr - r0), 32'd0);
      sync();
      issue(OP_ST, SZ_W, 1'b0, 30'h12, 32'h01020304, 5'd0);
      issue(OP_ST, SZ_H, 1'b0, 30'h21, 32'h00000506, 5'd0);
      chk("t4_no_bus_store", 32'(n_rd + n_wr - r0), 32'd0);
      issue(OP_LD, SZ_W, 1'b0, 30'h10, 32'h0, 5'd14);

      // Back-to-back load, pass-through, half store
      sync();
      pulse_q.delete();
      issue(OP_LD, SZ_W, 1'b0, 30'h10, 32'h0, 5'd6);
      issue(OP_NONE, SZ_W, 1'b0, 30'h0, 32'h00000005, 5'd3);
      issue(OP_ST, SZ_H, 1'b0, 30'h08, 32'h0000CAFE, 5'd0);
      chk("t5_in_ready_rmw", 32'(in_ready), 32'd0);
      sync();
      sync();
      chk("t5_pulse_count", 32'(pulse_q.size()), 32'd3);
      if (pulse_q.size() == 3) begin
         chk("t5_pulse2_offset", 32'(pulse_q[1] - pulse_q[0]), 32'd1);
         chk("t5_pulse3_offset", 32'(pulse_q[2] - pulse_q[0]), 32'd3);
      end
      issue(OP_LD, SZ_W, 1'b0, 30'h08, 32'h0, 5'd8);
      @(negedge clk);
      chk("t5_half_merge", wb_data, 32'hCAFEC3D4);
      sync();

      // Reserved encodings, rd=0 load, wrapped byte store
      issue(2'd3, SZ_W, 1'b0, 30'h0, 32'h00000077, 5'd11);
      issue(OP_LD, 2'd3, 1'b0, 30'h10, 32'h0, 5'd15);
      issue(OP_LD, SZ_W, 1'b0, 30'h20, 32'h0, 5'd0);
      issue(OP_NONE, SZ_W, 1'b0, 30'h0, 32'h12345678, 5'd0);
      issue(OP_ST, SZ_B, 1'b0, 30'h23, 32'hFFFFFF9C, 5'd0);
      issue(OP_LD, SZ_W, 1'b0, 30'h20, 32'h0, 5'd16);

      // Reset during RMW_WR drops the write
      sync();
      w0 = n_wr;
      issue(OP_ST, SZ_H, 1'b0, 30'h30, 32'h00001234, 5'd0);
      rst_ = 1'b0;
      #1;
      model_reset();
      chk_reset_state("rst_rmw");
      sync();
      sync();
      rst_ = 1'b1;
      sync();
      chk("t6_no_write", 32'(n_wr - w0), 32'd0);
      issue(OP_LD, SZ_H, 1'b1, 30'h30, 32'h0, 5'd10);
      @(negedge clk);
      chk("t6_mem_unchanged", wb_data, 32'h00005566);
      sync();
      issue(OP_LD, SZ_W, 1'b0, 30'h30, 32'h0, 5'd17);

      sync();
      sync();
      chk("model_queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
